bp_softcore_mem_router: RTL and testbench

Buffered command arbiter and response router that sits directly downstream of the softcore's two UCEs (I-side, source 0; D-side, source 1). It registers each UCE's memory command, round-robin arbitrates between them, and decodes the address to one of three targets: CLINT, host I/O or main memory. Per-source outstanding-request limits are enforced. Responses from the three targets are steered back to the issuing UCE by `payload.lce_id[0]`.

---
 rtl/bp_softcore_mem_router.sv | 205 ++++++++++++++++++++
 tb/tb_bp_softcore_mem_router.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_softcore_mem_router.sv
// Registers I-side/D-side UCE commands, round-robin arbitrates them to CLINT, host I/O or memory,
// enforces per-source credit limits, and steers target responses back by payload.lce_id[0].
module bp_softcore_mem_router #(
  parameter int unsigned bp_params_p       = 0,
  parameter int unsigned max_outstanding_p = 4,
  parameter logic [3:0]  clint_dev_p       = 4'h1,
  parameter logic [3:0]  host_dev_p        = 4'h2,
  localparam int unsigned cce_mem_msg_width_lp = 117
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,

  input  logic [1:0][cce_mem_msg_width_lp-1:0]  uce_cmd_i,
  input  logic [1:0]                            uce_cmd_v_i,
  output logic [1:0]                            uce_cmd_ready_o,
  output logic [1:0][cce_mem_msg_width_lp-1:0]  uce_resp_o,
  output logic [1:0]                            uce_resp_v_o,
  input  logic [1:0]                            uce_resp_yumi_i,

  output logic [cce_mem_msg_width_lp-1:0]       clint_cmd_o,
  output logic                                  clint_cmd_v_o,
  input  logic                                  clint_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0]       clint_resp_i,
  input  logic                                  clint_resp_v_i,
  output logic                                  clint_resp_yumi_o,

  output logic [cce_mem_msg_width_lp-1:0]       io_cmd_o,
  output logic                                  io_cmd_v_o,
  input  logic                                  io_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0]       io_resp_i,
  input  logic                                  io_resp_v_i,
  output logic                                  io_resp_yumi_o,

  output logic [cce_mem_msg_width_lp-1:0]       mem_cmd_o,
  output logic                                  mem_cmd_v_o,
  input  logic                                  mem_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0]       mem_resp_i,
  input  logic                                  mem_resp_v_i,
  output logic                                  mem_resp_yumi_o
);

  typedef struct packed {
    logic [2:0] lce_id;
    logic [2:0] way_id;
  } mem_payload_s;

  typedef struct packed {
    logic [3:0]   msg_type;
    logic [2:0]   size;
    logic [39:0]  addr;
    mem_payload_s payload;
    logic [63:0]  data;
  } mem_msg_s;

  logic [1:0][cce_mem_msg_width_lp-1:0] hold_q, hold_d;
  logic [1:0] hold_v_q, hold_v_d;
  logic [2:0] outst_q [2];
  logic [2:0] outst_d [2];
  logic       last_grant_q, last_grant_d;
  logic       lock_v_q, lock_v_d;
  logic       lock_src_q, lock_src_d;

  logic [1:0] elig;
  logic       grant_v, grant_src, fire;
  logic       is_local, tgt_clint, tgt_io, tgt_mem;
  logic [3:0] dev;
  mem_msg_s   gnt_msg;
  mem_msg_s   rmsg [3];
  logic [2:0] rv, rdst, rsel;
  logic [1:0] inc, dec;
  logic       unused_cfg;

  assign unused_cfg = ^32'(bp_params_p);

  assign uce_cmd_ready_o = ~hold_v_q & {2{reset_n_i}};

  // A grant that stalls on target backpressure is locked so the presented command cannot change.
  always_comb begin
    elig      = '0;
    grant_v   = 1'b0;
    grant_src = 1'b0;
    for (int unsigned s = 0; s < 2; s++) begin
      elig[s] = hold_v_q[s] && (outst_q[s] < 3'(max_outstanding_p));
    end
    if (lock_v_q) begin
      grant_v   = 1'b1;
      grant_src = lock_src_q;
    end else if (elig == 2'b11) begin
      grant_v   = 1'b1;
      grant_src = ~last_grant_q;
    end else if (elig[0]) begin
      grant_v   = 1'b1;
      grant_src = 1'b0;
    end else if (elig[1]) begin
      grant_v   = 1'b1;
      grant_src = 1'b1;
    end
  end

  assign gnt_msg   = hold_q[grant_src];
  assign is_local  = gnt_msg.addr < 40'h00_8000_0000;
  assign dev       = gnt_msg.addr[23:20];
  assign tgt_clint = is_local && (dev == clint_dev_p);
  assign tgt_io    = is_local && (dev == host_dev_p) && !tgt_clint;
  assign tgt_mem   = !tgt_clint && !tgt_io;

  assign clint_cmd_o   = gnt_msg;
  assign io_cmd_o      = gnt_msg;
  assign mem_cmd_o     = gnt_msg;
  assign clint_cmd_v_o = grant_v && tgt_clint;
  assign io_cmd_v_o    = grant_v && tgt_io;
  assign mem_cmd_v_o   = grant_v && tgt_mem;
  assign fire = (clint_cmd_v_o && clint_cmd_ready_i)
             || (io_cmd_v_o && io_cmd_ready_i)
             || (mem_cmd_v_o && mem_cmd_ready_i);

  always_comb begin
    hold_d       = hold_q;
    hold_v_d     = hold_v_q;
    inc          = '0;
    for (int unsigned s = 0; s < 2; s++) begin
      if (fire && (grant_src == 1'(s))) begin
        hold_v_d[s] = 1'b0;
        inc[s]      = 1'b1;
      end
      if (uce_cmd_v_i[s] && uce_cmd_ready_o[s]) begin
        hold_d[s]   = uce_cmd_i[s];
        hold_v_d[s] = 1'b1;
      end
    end
    lock_v_d     = grant_v && !fire;
    lock_src_d   = grant_src;
    last_grant_d = fire ? grant_src : last_grant_q;
  end

  assign rmsg[0] = clint_resp_i;
  assign rmsg[1] = io_resp_i;
  assign rmsg[2] = mem_resp_i;
  assign rv      = {mem_resp_v_i, io_resp_v_i, clint_resp_v_i} & {3{reset_n_i}};

  // Index order is priority order: each destination takes the first valid response aimed at it.
  always_comb begin
    uce_resp_v_o = '0;
    uce_resp_o   = '0;
    rsel         = '0;
    rdst         = '0;
    for (int unsigned t = 0; t < 3; t++) begin
      rdst[t] = rmsg[t].payload.lce_id[0];
      for (int unsigned d = 0; d < 2; d++) begin
        if (rv[t] && (rdst[t] == 1'(d)) && !uce_resp_v_o[d]) begin
          uce_resp_v_o[d] = 1'b1;
          uce_resp_o[d]   = rmsg[t];
          rsel[t]         = 1'b1;
        end
      end
    end
  end

  assign clint_resp_yumi_o = rsel[0] && uce_resp_yumi_i[rdst[0]];
  assign io_resp_yumi_o    = rsel[1] && uce_resp_yumi_i[rdst[1]];
  assign mem_resp_yumi_o   = rsel[2] && uce_resp_yumi_i[rdst[2]];
  assign dec               = uce_resp_v_o & uce_resp_yumi_i;

  always_comb begin
    for (int unsigned s = 0; s < 2; s++) begin
      outst_d[s] = outst_q[s];
      if (inc[s] && !dec[s]) begin
        outst_d[s] = outst_q[s] + 3'd1;
      end else if (dec[s] && !inc[s] && (outst_q[s] != '0)) begin
        outst_d[s] = outst_q[s] - 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hold_q       <= '0;
      hold_v_q     <= '0;
      last_grant_q <= 1'b1;
      lock_v_q     <= 1'b0;
      lock_src_q   <= 1'b0;
      for (int unsigned s = 0; s < 2; s++) begin
        outst_q[s] <= '0;
      end
    end else begin
      hold_q       <= hold_d;
      hold_v_q     <= hold_v_d;
      last_grant_q <= last_grant_d;
      lock_v_q     <= lock_v_d;
      lock_src_q   <= lock_src_d;
      for (int unsigned s = 0; s < 2; s++) begin
        outst_q[s] <= outst_d[s];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      for (int unsigned s = 0; s < 2; s++) begin
        assert (!(dec[s] && !inc[s] && (outst_q[s] == '0)));
      end
    end
  end

endmodule

// File: tb/tb_bp_softcore_mem_router.sv
// Directed-plus-random bench for bp_softcore_mem_router with an address-rule reference model.
module tb_bp_softcore_mem_router;
  localparam int W = 117;

  typedef struct packed {
    logic [2:0] lce_id;
    logic [2:0] way_id;
  } pay_t;
  typedef struct packed {
    logic [3:0]  msg_type;
    logic [2:0]  size;
    logic [39:0] addr;
    pay_t        payload;
    logic [63:0] data;
  } msg_t;

  logic clk = 1'b0;
  logic reset_n;
  logic [1:0][W-1:0] uce_cmd_i, uce_resp_o;
  logic [1:0] uce_cmd_v_i, uce_cmd_ready_o, uce_resp_v_o, uce_resp_yumi_i;
  logic [W-1:0] clint_cmd_o, io_cmd_o, mem_cmd_o, clint_resp_i, io_resp_i, mem_resp_i;
  logic clint_cmd_v_o, io_cmd_v_o, mem_cmd_v_o;
  logic clint_cmd_ready_i, io_cmd_ready_i, mem_cmd_ready_i;
  logic clint_resp_v_i, io_resp_v_i, mem_resp_v_i;
  logic clint_resp_yumi_o, io_resp_yumi_o, mem_resp_yumi_o;

  bp_softcore_mem_router #(.max_outstanding_p(4), .clint_dev_p(4'h1), .host_dev_p(4'h2)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .uce_cmd_i(uce_cmd_i), .uce_cmd_v_i(uce_cmd_v_i), .uce_cmd_ready_o(uce_cmd_ready_o),
    .uce_resp_o(uce_resp_o), .uce_resp_v_o(uce_resp_v_o), .uce_resp_yumi_i(uce_resp_yumi_i),
    .clint_cmd_o(clint_cmd_o), .clint_cmd_v_o(clint_cmd_v_o), .clint_cmd_ready_i(clint_cmd_ready_i),
    .clint_resp_i(clint_resp_i), .clint_resp_v_i(clint_resp_v_i), .clint_resp_yumi_o(clint_resp_yumi_o),
    .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_i(io_cmd_ready_i),
    .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o)
  );

  always #5 clk = ~clk;

  int unsigned total = 0, passed = 0, failed = 0;
  int exp_out [2];
  int exp_last;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mk(input logic [39:0] addr, input logic src);
    msg_t m;
    m.msg_type = 4'($urandom);
    m.size     = 3'($urandom);
    m.addr     = addr;
    m.payload.lce_id = {2'($urandom), src};
    m.payload.way_id = 3'($urandom);
    m.data     = {$urandom, $urandom};
    return m;
  endfunction

  // Reference decode: low 2 GiB is local; device nibble addr[23:20] picks CLINT / host I/O.
  function automatic int ref_target(input logic [39:0] a);
    if (a < 40'h00_8000_0000 && a[23:20] == 4'h1) return 0;
    if (a < 40'h00_8000_0000 && a[23:20] == 4'h2) return 1;
    return 2;
  endfunction

  function automatic logic [39:0] rand_addr(input int t);
    logic [3:0] dev;
    case (t)
      0: dev = 4'h1;
      1: dev = 4'h2;
      default: begin
        if ($urandom_range(0, 1) == 1) return {9'($urandom_range(1, 511)), 31'($urandom)};
        dev = 4'($urandom_range(3, 16));
      end
    endcase
    return {9'h0, 7'($urandom), dev, 20'($urandom)};
  endfunction

  function automatic logic [W-1:0] tgt_data(input int t);
    case (t)
      0: return clint_cmd_o;
      1: return io_cmd_o;
      default: return mem_cmd_o;
    endcase
  endfunction

  task automatic chk_out(input string tag);
    chk({tag, "_out0"}, 128'(dut.outst_q[0]), 128'(exp_out[0]));
    chk({tag, "_out1"}, 128'(dut.outst_q[1]), 128'(exp_out[1]));
  endtask

  task automatic issue_one(input int s, input logic [39:0] addr, input string tag);
    logic [W-1:0] m;
    int t;
    m = mk(addr, 1'(s));
    t = ref_target(addr);
    uce_cmd_i[s] = m;
    uce_cmd_v_i[s] = 1'b1;
    #1 chk({tag, "_ready"}, 128'(uce_cmd_ready_o[s]), 128'(1));
    tick();
    uce_cmd_v_i[s] = 1'b0;
    #1 chk({tag, "_tgt_v"}, 128'({mem_cmd_v_o, io_cmd_v_o, clint_cmd_v_o}), 128'(3'b001 << t));
    chk({tag, "_tgt_data"}, 128'(tgt_data(t)), 128'(m));
    tick();
    exp_out[s]++;
    exp_last = s;
  endtask

  task automatic deliver(input int s, input int n);
    logic [W-1:0] r;
    for (int i = 0; i < n; i++) begin
      r = mk({9'h1ff, 31'($urandom)}, 1'(s));
      mem_resp_i = r;
      mem_resp_v_i = 1'b1;
      uce_resp_yumi_i = 2'b01 << s;
      #1 chk("drain_v", 128'(uce_resp_v_o[s]), 128'(1));
      chk("drain_data", 128'(uce_resp_o[s]), 128'(r));
      chk("drain_yumi", 128'(mem_resp_yumi_o), 128'(1));
      tick();
      exp_out[s]--;
    end
    mem_resp_v_i = 1'b0;
    uce_resp_yumi_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] m0, m1, m5, rc, ri, rm;
    logic [W-1:0] sentq [2][$];
    int grants [$];
    int cap [2];
    logic [1:0] cap_now;
    int exp_first, src;
    msg_t tmp;

    reset_n = 1'b0;
    uce_cmd_i = '0; uce_cmd_v_i = 2'b11; uce_resp_yumi_i = 2'b11;
    clint_cmd_ready_i = 1'b1; io_cmd_ready_i = 1'b1; mem_cmd_ready_i = 1'b1;
    clint_resp_i = '0; io_resp_i = '0; mem_resp_i = '0;
    clint_resp_v_i = 1'b0; io_resp_v_i = 1'b0; mem_resp_v_i = 1'b1;
    exp_out[0] = 0; exp_out[1] = 0; exp_last = 1;
    tick(); tick();
    chk("rst_ready", 128'(uce_cmd_ready_o), 128'(0));
    chk("rst_cmd_v", 128'({mem_cmd_v_o, io_cmd_v_o, clint_cmd_v_o}), 128'(0));
    chk("rst_resp_v", 128'(uce_resp_v_o), 128'(0));
    chk("rst_yumi", 128'({mem_resp_yumi_o, io_resp_yumi_o, clint_resp_yumi_o}), 128'(0));
    uce_cmd_v_i = '0; uce_resp_yumi_i = '0; mem_resp_v_i = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("post_rst_ready", 128'(uce_cmd_ready_o), 128'(2'b11));
    chk_out("post_rst");

    // Directed decode
    issue_one(0, 40'h00_0010_0000, "dec_clint");
    issue_one(0, 40'h00_0020_0000, "dec_io");
    issue_one(0, 40'h00_8000_1000, "dec_mem");
    chk_out("dec");
    deliver(0, 3);

    // Randomised decode
    for (int i = 0; i < 8; i++) begin
      src = $urandom_range(0, 1);
      issue_one(src, rand_addr($urandom_range(0, 2)), "rnd_dec");
      deliver(src, 1);
    end

    // Round-robin with both sources streaming memory commands
    cap[0] = 0; cap[1] = 0;
    exp_first = 1 - exp_last;
    uce_cmd_i[0] = mk(rand_addr(2), 1'b0);
    uce_cmd_i[1] = mk(rand_addr(2), 1'b1);
    uce_cmd_v_i = 2'b11;
    for (int cyc = 0; cyc < 24 && grants.size() < 4; cyc++) begin
      #1;
      if (mem_cmd_v_o) begin
        tmp = mem_cmd_o;
        src = int'(tmp.payload.lce_id[0]);
        grants.push_back(src);
        if (sentq[src].size() > 0) begin
          chk("rr_data", 128'(mem_cmd_o), 128'(sentq[src][0]));
          void'(sentq[src].pop_front());
        end else chk("rr_unsent_cmd", 128'(0), 128'(1));
      end
      cap_now = '0;
      for (int s = 0; s < 2; s++) begin
        if (uce_cmd_v_i[s] && uce_cmd_ready_o[s]) begin
          sentq[s].push_back(uce_cmd_i[s]);
          cap[s]++;
          cap_now[s] = 1'b1;
        end
      end
      tick();
      for (int s = 0; s < 2; s++) begin
        if (cap_now[s]) begin
          if (cap[s] < 2) uce_cmd_i[s] = mk(rand_addr(2), 1'(s));
          else uce_cmd_v_i[s] = 1'b0;
        end
      end
    end
    uce_cmd_v_i = '0;
    chk("rr_count", 128'(grants.size()), 128'(4));
    for (int i = 0; i < grants.size(); i++) chk("rr_order", 128'(grants[i]), 128'((exp_first + i) % 2));
    exp_out[0] += 2; exp_out[1] += 2;
    exp_last = (exp_first + 3) % 2;
    chk_out("rr");
    deliver(0, 2);
    deliver(1, 2);

    // Backpressure: source 0 stalled while source 1 waits, with tie-break favouring source 1
    issue_one(0, rand_addr(2), "bp_pre");
    mem_cmd_ready_i = 1'b0;
    m0 = mk(rand_addr(2), 1'b0);
    m1 = mk(rand_addr(2), 1'b1);
    uce_cmd_i[0] = m0; uce_cmd_v_i = 2'b01;
    tick();
    uce_cmd_i[1] = m1; uce_cmd_v_i = 2'b10;
    tick();
    uce_cmd_v_i = '0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_v", 128'(mem_cmd_v_o), 128'(1));
      chk("bp_stable", 128'(mem_cmd_o), 128'(m0));
      tick();
    end
    mem_cmd_ready_i = 1'b1;
    #1 chk("bp_release", 128'(mem_cmd_o), 128'(m0));
    tick();
    #1 chk("bp_next", 128'(mem_cmd_o), 128'(m1));
    chk("bp_next_v", 128'(mem_cmd_v_o), 128'(1));
    tick();
    exp_out[0]++; exp_out[1]++; exp_last = 1;
    chk_out("bp");
    deliver(0, 2);
    deliver(1, 1);

    // Credit limit on source 1
    for (int i = 0; i < 4; i++) issue_one(1, rand_addr($urandom_range(0, 2)), "cr_fill");
    m5 = mk(rand_addr(2), 1'b1);
    uce_cmd_i[1] = m5; uce_cmd_v_i = 2'b10;
    tick();
    uce_cmd_v_i = '0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("cr_held_v", 128'(mem_cmd_v_o), 128'(0));
      chk("cr_held_ready", 128'(uce_cmd_ready_o[1]), 128'(0));
      tick();
    end
    mem_resp_i = mk({9'h1ff, 31'($urandom)}, 1'b1);
    mem_resp_v_i = 1'b1; uce_resp_yumi_i = 2'b10;
    #1 chk("cr_resp_yumi", 128'(mem_resp_yumi_o), 128'(1));
    tick();
    exp_out[1]--;
    mem_resp_v_i = 1'b0; uce_resp_yumi_i = '0;
    #1 chk("cr_issue_v", 128'(mem_cmd_v_o), 128'(1));
    chk("cr_issue_data", 128'(mem_cmd_o), 128'(m5));
    tick();
    exp_out[1]++;
    chk_out("cr");

    // Simultaneous responses
    issue_one(0, rand_addr($urandom_range(0, 2)), "sim_pre");
    issue_one(0, rand_addr($urandom_range(0, 2)), "sim_pre");
    rc = mk(rand_addr(0), 1'b0);
    ri = mk(rand_addr(1), 1'b1);
    rm = mk(rand_addr(2), 1'b0);
    clint_resp_i = rc; io_resp_i = ri; mem_resp_i = rm;
    clint_resp_v_i = 1'b1; io_resp_v_i = 1'b1; mem_resp_v_i = 1'b1;
    uce_resp_yumi_i = '0;
    #1 chk("sim_noyumi_v", 128'(uce_resp_v_o), 128'(2'b11));
    chk("sim_noyumi", 128'({mem_resp_yumi_o, io_resp_yumi_o, clint_resp_yumi_o}), 128'(0));
    uce_resp_yumi_i = 2'b11;
    #1 chk("sim_src0", 128'(uce_resp_o[0]), 128'(rc));
    chk("sim_src1", 128'(uce_resp_o[1]), 128'(ri));
    chk("sim_yumi", 128'({mem_resp_yumi_o, io_resp_yumi_o, clint_resp_yumi_o}), 128'(3'b011));
    tick();
    clint_resp_v_i = 1'b0; io_resp_v_i = 1'b0;
    #1 chk("sim_mem_v", 128'(uce_resp_v_o), 128'(2'b01));
    chk("sim_mem_data", 128'(uce_resp_o[0]), 128'(rm));
    chk("sim_mem_yumi", 128'(mem_resp_yumi_o), 128'(1));
    tick();
    mem_resp_v_i = 1'b0; uce_resp_yumi_i = '0;
    exp_out[0] -= 2; exp_out[1] -= 1;
    chk_out("sim");

    // Reset mid-stream
    mem_cmd_ready_i = 1'b0;
    uce_cmd_i[0] = mk(rand_addr(2), 1'b0);
    uce_cmd_i[1] = mk(rand_addr(2), 1'b1);
    uce_cmd_v_i = 2'b11;
    tick();
    uce_cmd_v_i = '0;
    #1 chk("mid_pre_v", 128'(mem_cmd_v_o), 128'(1));
    reset_n = 1'b0;
    exp_out[0] = 0; exp_out[1] = 0; exp_last = 1;
    #1 chk("mid_v", 128'({mem_cmd_v_o, io_cmd_v_o, clint_cmd_v_o}), 128'(0));
    chk("mid_ready", 128'(uce_cmd_ready_o), 128'(0));
    chk_out("mid");
    tick();
    reset_n = 1'b1;
    mem_cmd_ready_i = 1'b1;
    m0 = mk(rand_addr(2), 1'b0);
    m1 = mk(rand_addr(2), 1'b1);
    uce_cmd_i[0] = m0; uce_cmd_i[1] = m1; uce_cmd_v_i = 2'b11;
    tick();
    uce_cmd_v_i = '0;
    #1 chk("mid_first", 128'(mem_cmd_o), 128'(exp_last == 1 ? m0 : m1));
    tick();
    #1 chk("mid_second", 128'(mem_cmd_o), 128'(exp_last == 1 ? m1 : m0));
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
